mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of EX. Holds the EX/MEM and MEM/WB pipeline registers.
- Performs data-memory loads and stores through a req/ready handshake with a wait-state timeout.
- Selects the writeback data.
- Drives the MEM-side and WB-side signals consumed by the EX forwarding unit and the hazard unit, and generates the memory stall for the upstream stages.

Parameters:
- TIMEOUT, 16, maximum cycles a memory access may stay in ACCESS before abort; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- intterupt  in  1  squash the instruction being captured from EX
- ALUoutEX  in  32  ALU result / memory address
- memwritedataEX  in  32  store data (forwarded rt)
- regwriteaddrEX  in  5  destination register
- PCplus4EX  in  32  link value for jal/jalr
- RegWriteEX  in  1  register write enable
- MemReadEX  in  1  load
- MemWriteEX  in  1  store
- MemtoRegEX  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 reserved (treated as 00)
- dmem_ready  in  1  memory accepts/completes the current access
- dmem_rdata  in  32  load data, valid when dmem_req && dmem_ready
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  store data
- ALUoutMEM  out  32  EX/MEM ALU result (forwarding)
- regwriteaddrMEM  out  5  EX/MEM destination (forwarding)
- RegWriteMEM  out  1  EX/MEM write enable (forwarding)
- MemReadMEM  out  1  load in MEM (hazard unit)
- memstall  out  1  freeze PC, IF/ID and ID/EX
- regwritedataWB  out  32  writeback data
- regwriteaddrWB  out  5  writeback destination
- RegWriteWB  out  1  writeback enable
- bus_error  out  1  one-cycle pulse, access aborted by timeout

Behaviour:
- Reset: all registers 0, FSM in IDLE, wait_cnt 0, all outputs 0.
- EX/MEM register, when memstall=0:
  - intterupt=1: capture a bubble (all controls and data 0).
  - otherwise: capture all EX inputs.
- EX/MEM register, when memstall=1: hold all values; intterupt is ignored.
- FSM has two states, IDLE and ACCESS:
  - next state is ACCESS iff the register is capturing a non-bubble op with MemReadEX or MemWriteEX set; otherwise IDLE.
  - wait_cnt clears on every capture.
  - MemRead and MemWrite both set: treated as a store.
- In ACCESS:
  - dmem_req=1, dmem_we=MemWriteMEM, dmem_addr=ALUoutMEM, dmem_wdata=memwritedataMEM.
  - All four are stable while req is high.
  - In IDLE, dmem_req and dmem_we are 0.
- Completion: the cycle with dmem_ready=1 in ACCESS. memstall=0 that cycle, and dmem_rdata is sampled into MEM/WB.
- Waiting: ACCESS with dmem_ready=0 and wait_cnt < TIMEOUT-1. memstall=1 and wait_cnt increments.
- Abort: ACCESS with dmem_ready=0 and wait_cnt == TIMEOUT-1.
  - memstall=0 that cycle.
  - MEM/WB captures with RegWriteWB forced 0.
  - bus_error=1 in the following cycle only.
- Zero-wait memory (dmem_ready tied 1): every access takes one cycle and memstall is never asserted.
- memstall = (state==ACCESS) && !dmem_ready && !abort. It is purely combinational from state, wait_cnt and dmem_ready.
- MEM/WB register, updated every cycle:
  - memstall=1: capture a bubble (RegWriteWB=0, data and addr 0).
  - memstall=0, writeback data by MemtoRegMEM: 00 ALUoutMEM, 01 dmem_rdata, 10 PCplus4MEM.
  - memstall=0: regwriteaddrWB = regwriteaddrMEM; RegWriteWB = RegWriteMEM && !abort.
- Latency:
  - EX input to MEM outputs: 1 cycle.
  - EX input to WB outputs: 2 cycles plus the number of stall cycles.
- Reset asserted mid-access: FSM returns to IDLE, req drops the next cycle, no writeback and no bus_error. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - MemtoReg encodings (MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_PC4=2'b10)
  - FSM state encoding (IDLE, ACCESS)
  - link register constant 5'd31
- One sub-module, dmem_access_fsm. It owns state, wait_cnt, memstall, abort and the bus_error pulse. Pipeline registers and the writeback mux stay in mem_stage.

Test Plan:
- Reset held 0 for 2 cycles with RegWriteEX=1, MemReadEX=1 -> all outputs 0, dmem_req=0.
- ALU op: ALUoutEX=0x00000010, regwriteaddrEX=8, RegWriteEX=1, MemtoReg=00 -> next cycle ALUoutMEM=0x10, RegWriteMEM=1; cycle after, regwritedataWB=0x10, regwriteaddrWB=8, RegWriteWB=1; dmem_req never 1.
- Load, 2 wait states: ALUoutEX=0x100, rt=9, MemtoReg=01; dmem_ready low 2 cycles then high with rdata 0xDEADBEEF -> dmem_req high 3 cycles at addr 0x100, memstall high 2 cycles, RegWriteWB=0 during stall, then regwritedataWB=0xDEADBEEF, addr 9, RegWriteWB=1.
- Store, zero-wait: ALUoutEX=0x200, memwritedataEX=0x12345678, ready tied 1 -> dmem_req=dmem_we=1 for exactly 1 cycle with that addr/data; memstall never 1; RegWriteWB=0.
- Timeout: TIMEOUT=4, load with dmem_ready held 0 -> dmem_req 4 cycles, memstall 3 cycles, bus_error single pulse in the next cycle, RegWriteWB stays 0, following instruction proceeds.
- jal plus interrupt:
  - MemtoReg=10, PCplus4EX=0x00400008, regwriteaddrEX=31 -> regwritedataWB=0x00400008, regwriteaddrWB=31.
  - intterupt=1 while capturing an op with RegWriteEX=1 -> RegWriteMEM=0 next cycle.
  - intterupt=1 during memstall -> ignored; the held op completes.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: writeback select, access FSM
// states and the EX/MEM pipeline register layout.
package mem_stage_pkg;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_PC4  = 2'b10;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [1:0]  mtr;
  } exmem_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: tracks the outstanding access, counts wait
// states, and produces the stall, timeout abort and bus_error pulse.
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_ready,
  output logic o_access,
  output logic o_memstall,
  output logic o_abort,
  output logic o_bus_error
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;
  logic       r_bus_error;
  logic       w_in_access;
  logic       w_abort;
  logic       w_stall;

  always_comb begin
    w_in_access = (r_state == ACCESS);
    w_abort     = w_in_access && !i_ready && (r_wait_cnt == LAST_WAIT);
    w_stall     = w_in_access && !i_ready && !w_abort;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (w_stall) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end else begin
      // Not stalling means the pipeline register captures this cycle.
      w_wait_nxt  = '0;
      w_state_nxt = i_start ? ACCESS : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_bus_error <= w_abort;
    end
  end

  assign o_access    = w_in_access;
  assign o_memstall  = w_stall;
  assign o_abort     = w_abort;
  assign o_bus_error = r_bus_error;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, data-memory handshake,
// writeback select, and forwarding/hazard/stall outputs.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intterupt,
  input  logic [31:0] ALUoutEX,
  input  logic [31:0] memwritedataEX,
  input  logic [4:0]  regwriteaddrEX,
  input  logic [31:0] PCplus4EX,
  input  logic        RegWriteEX,
  input  logic        MemReadEX,
  input  logic        MemWriteEX,
  input  logic [1:0]  MemtoRegEX,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] ALUoutMEM,
  output logic [4:0]  regwriteaddrMEM,
  output logic        RegWriteMEM,
  output logic        MemReadMEM,
  output logic        memstall,
  output logic [31:0] regwritedataWB,
  output logic [4:0]  regwriteaddrWB,
  output logic        RegWriteWB,
  output logic        bus_error
);

  exmem_t      r_exmem;
  exmem_t      w_ex_in;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_addr;
  logic        r_wb_we;
  logic [31:0] w_wb_data;
  logic        w_start;
  logic        w_access;
  logic        w_memstall;
  logic        w_abort;
  logic        w_bus_error;

  always_comb begin
    w_ex_in = '{alu: ALUoutEX, wdata: memwritedataEX, pc4: PCplus4EX,
                rd: regwriteaddrEX, regwrite: RegWriteEX, memread: MemReadEX,
                memwrite: MemWriteEX, mtr: MemtoRegEX};
    w_start = !intterupt && (MemReadEX || MemWriteEX);
  end

  dmem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_ready     (dmem_ready),
    .o_access    (w_access),
    .o_memstall  (w_memstall),
    .o_abort     (w_abort),
    .o_bus_error (w_bus_error)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_exmem <= '0;
    end else if (!w_memstall) begin
      r_exmem <= intterupt ? '0 : w_ex_in;
    end
  end

  always_comb begin
    case (r_exmem.mtr)
      MTR_MEM: w_wb_data = dmem_rdata;
      MTR_PC4: w_wb_data = r_exmem.pc4;
      default: w_wb_data = r_exmem.alu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || w_memstall) begin
      r_wb_data <= '0;
      r_wb_addr <= '0;
      r_wb_we   <= 1'b0;
    end else begin
      r_wb_data <= w_wb_data;
      r_wb_addr <= r_exmem.rd;
      r_wb_we   <= r_exmem.regwrite && !w_abort;
    end
  end

  // Store wins when both read and write are flagged.
  assign dmem_req        = w_access;
  assign dmem_we         = w_access && r_exmem.memwrite;
  assign dmem_addr       = r_exmem.alu;
  assign dmem_wdata      = r_exmem.wdata;
  assign ALUoutMEM       = r_exmem.alu;
  assign regwriteaddrMEM = r_exmem.rd;
  assign RegWriteMEM     = r_exmem.regwrite;
  assign MemReadMEM      = r_exmem.memread;
  assign memstall        = w_memstall;
  assign regwritedataWB  = r_wb_data;
  assign regwriteaddrWB  = r_wb_addr;
  assign RegWriteWB      = r_wb_we;
  assign bus_error       = w_bus_error;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inline checks per step plus a writeback
// scoreboard that pairs each expected writeback with the observed one.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        intterupt;
  logic [31:0] ALUoutEX, memwritedataEX, PCplus4EX;
  logic [4:0]  regwriteaddrEX;
  logic        RegWriteEX, MemReadEX, MemWriteEX;
  logic [1:0]  MemtoRegEX;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, ALUoutMEM;
  logic [4:0]  regwriteaddrMEM;
  logic        RegWriteMEM, MemReadMEM, memstall;
  logic [31:0] regwritedataWB;
  logic [4:0]  regwriteaddrWB;
  logic        RegWriteWB, bus_error;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
  } wb_t;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .intterupt(intterupt),
    .ALUoutEX(ALUoutEX), .memwritedataEX(memwritedataEX),
    .regwriteaddrEX(regwriteaddrEX), .PCplus4EX(PCplus4EX),
    .RegWriteEX(RegWriteEX), .MemReadEX(MemReadEX), .MemWriteEX(MemWriteEX),
    .MemtoRegEX(MemtoRegEX), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .ALUoutMEM(ALUoutMEM),
    .regwriteaddrMEM(regwriteaddrMEM), .RegWriteMEM(RegWriteMEM),
    .MemReadMEM(MemReadMEM), .memstall(memstall),
    .regwritedataWB(regwritedataWB), .regwriteaddrWB(regwriteaddrWB),
    .RegWriteWB(RegWriteWB), .bus_error(bus_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ALUoutEX = '0; memwritedataEX = '0; PCplus4EX = '0; regwriteaddrEX = '0;
    RegWriteEX = 1'b0; MemReadEX = 1'b0; MemWriteEX = 1'b0; MemtoRegEX = '0;
  endtask

  // Every asserted writeback must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wb_t e;
    if (RegWriteWB === 1'b1) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL wb_unexpected: observed write %h to r%0d expected none", regwritedataWB, regwriteaddrWB);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_wb_data", regwritedataWB, e.data);
        check("sb_wb_addr", {27'd0, regwriteaddrWB}, {27'd0, e.addr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; intterupt = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    clear_ex();
    RegWriteEX = 1'b1; MemReadEX = 1'b1;
    tick(); tick();
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_alu_mem", ALUoutMEM, 0);
    check("rst_rw_mem", RegWriteMEM, 0);
    check("rst_mr_mem", MemReadMEM, 0);
    check("rst_stall", memstall, 0);
    check("rst_wb_data", regwritedataWB, 0);
    check("rst_rw_wb", RegWriteWB, 0);
    check("rst_buserr", bus_error, 0);

    // ALU op
    reset = 1'b1; clear_ex();
    ALUoutEX = 32'h10; regwriteaddrEX = 5'd8; RegWriteEX = 1'b1; MemtoRegEX = MTR_ALU;
    sb.push_back('{32'h10, 5'd8});
    tick(); clear_ex();
    check("alu_mem", ALUoutMEM, 32'h10);
    check("alu_rw_mem", RegWriteMEM, 1);
    check("alu_req", dmem_req, 0);
    tick();
    check("alu_wb_data", regwritedataWB, 32'h10);
    check("alu_wb_addr", regwriteaddrWB, 8);
    check("alu_rw_wb", RegWriteWB, 1);
    check("alu_req2", dmem_req, 0);

    // Load with two wait states
    ALUoutEX = 32'h100; regwriteaddrEX = 5'd9; RegWriteEX = 1'b1; MemReadEX = 1'b1;
    MemtoRegEX = MTR_MEM; dmem_ready = 1'b0;
    sb.push_back('{32'hDEADBEEF, 5'd9});
    tick(); clear_ex(); #1;
    check("ld_req0", dmem_req, 1);
    check("ld_we0", dmem_we, 0);
    check("ld_addr0", dmem_addr, 32'h100);
    check("ld_stall0", memstall, 1);
    check("ld_mr_mem", MemReadMEM, 1);
    check("ld_rw_wb0", RegWriteWB, 0);
    tick();
    check("ld_req1", dmem_req, 1);
    check("ld_stall1", memstall, 1);
    check("ld_rw_wb1", RegWriteWB, 0);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF; #1;
    check("ld_req2", dmem_req, 1);
    check("ld_addr2", dmem_addr, 32'h100);
    check("ld_stall2", memstall, 0);
    tick();
    dmem_ready = 1'b0;
    check("ld_wb_data", regwritedataWB, 32'hDEADBEEF);
    check("ld_wb_addr", regwriteaddrWB, 9);
    check("ld_rw_wb", RegWriteWB, 1);
    check("ld_req3", dmem_req, 0);

    // Zero-wait stores, second one flags both read and write
    dmem_ready = 1'b1;
    ALUoutEX = 32'h200; memwritedataEX = 32'h12345678; MemWriteEX = 1'b1;
    tick();
    ALUoutEX = 32'h204; memwritedataEX = 32'hCAFEF00D; MemWriteEX = 1'b1; MemReadEX = 1'b1;
    #1;
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_addr", dmem_addr, 32'h200);
    check("st_wdata", dmem_wdata, 32'h12345678);
    check("st_stall", memstall, 0);
    tick(); clear_ex(); #1;
    check("st2_req", dmem_req, 1);
    check("st2_we", dmem_we, 1);
    check("st2_addr", dmem_addr, 32'h204);
    check("st2_wdata", dmem_wdata, 32'hCAFEF00D);
    check("st2_stall", memstall, 0);
    tick();
    check("st_req_end", dmem_req, 0);
    check("st_we_end", dmem_we, 0);
    check("st_rw_wb", RegWriteWB, 0);
    dmem_ready = 1'b0;

    // Timeout abort (TIMEOUT=4) with a following ALU op held in EX
    ALUoutEX = 32'h300; regwriteaddrEX = 5'd10; RegWriteEX = 1'b1; MemReadEX = 1'b1;
    MemtoRegEX = MTR_MEM;
    tick();
    clear_ex();
    ALUoutEX = 32'h55; regwriteaddrEX = 5'd11; RegWriteEX = 1'b1;
    sb.push_back('{32'h55, 5'd11});
    #1;
    check("to_req0", dmem_req, 1);
    check("to_stall0", memstall, 1);
    tick();
    check("to_stall1", memstall, 1);
    check("to_buserr1", bus_error, 0);
    tick();
    check("to_stall2", memstall, 1);
    tick();
    check("to_req3", dmem_req, 1);
    check("to_stall3", memstall, 0);
    check("to_buserr3", bus_error, 0);
    tick();
    clear_ex();
    check("to_req_end", dmem_req, 0);
    check("to_buserr", bus_error, 1);
    check("to_rw_wb", RegWriteWB, 0);
    check("to_next_mem", ALUoutMEM, 32'h55);
    check("to_next_rw", RegWriteMEM, 1);
    tick();
    check("to_buserr_end", bus_error, 0);
    check("to_next_wb", regwritedataWB, 32'h55);
    check("to_next_rw_wb", RegWriteWB, 1);

    // jal writeback of PC+4 to the link register
    MemtoRegEX = MTR_PC4; PCplus4EX = 32'h00400008; regwriteaddrEX = LINK_REG;
    RegWriteEX = 1'b1; ALUoutEX = 32'h77;
    sb.push_back('{32'h00400008, LINK_REG});
    tick(); clear_ex();
    tick();
    check("jal_wb_data", regwritedataWB, 32'h00400008);
    check("jal_wb_addr", regwriteaddrWB, 31);
    check("jal_rw_wb", RegWriteWB, 1);

    // Interrupt squashes the captured op
    ALUoutEX = 32'h99; regwriteaddrEX = 5'd12; RegWriteEX = 1'b1; intterupt = 1'b1;
    tick();
    intterupt = 1'b0; clear_ex();
    check("irq_rw_mem", RegWriteMEM, 0);
    check("irq_alu_mem", ALUoutMEM, 0);
    check("irq_rd_mem", regwriteaddrMEM, 0);
    tick();
    check("irq_rw_wb", RegWriteWB, 0);

    // Interrupt during memstall is ignored
    ALUoutEX = 32'h400; regwriteaddrEX = 5'd13; RegWriteEX = 1'b1; MemReadEX = 1'b1;
    MemtoRegEX = MTR_MEM;
    sb.push_back('{32'h0BADF00D, 5'd13});
    tick();
    clear_ex(); intterupt = 1'b1; #1;
    check("irqs_stall", memstall, 1);
    tick();
    check("irqs_alu_mem", ALUoutMEM, 32'h400);
    check("irqs_rw_mem", RegWriteMEM, 1);
    check("irqs_mr_mem", MemReadMEM, 1);
    check("irqs_req", dmem_req, 1);
    dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D; intterupt = 1'b0;
    tick();
    dmem_ready = 1'b0;
    check("irqs_wb_data", regwritedataWB, 32'h0BADF00D);
    check("irqs_wb_addr", regwriteaddrWB, 13);
    check("irqs_rw_wb", RegWriteWB, 1);

    // Reset mid-access
    ALUoutEX = 32'h500; regwriteaddrEX = 5'd14; RegWriteEX = 1'b1; MemReadEX = 1'b1;
    MemtoRegEX = MTR_MEM;
    tick(); clear_ex(); #1;
    check("rma_req", dmem_req, 1);
    reset = 1'b0;
    tick();
    check("rma_req_drop", dmem_req, 0);
    check("rma_stall", memstall, 0);
    check("rma_rw_mem", RegWriteMEM, 0);
    reset = 1'b1;
    tick();
    check("rma_rw_wb", RegWriteWB, 0);
    check("rma_buserr", bus_error, 0);
    tick();
    check("rma_buserr2", bus_error, 0);
    check("rma_rw_wb2", RegWriteWB, 0);

    tick();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
